// File: rtl/mole_spawner_pkg.sv
// Shared types and widths for the whack-a-mole spawner.
package mole_pkg;

  localparam int SCORE_W = 8;
  localparam int HOLE_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PICK,
    ST_UP,
    ST_GAP
  } state_t;

  // Deterministic fallback hole: the one after the previous pick, wrapping.
  function automatic logic [HOLE_W-1:0] nextHole(input logic [HOLE_W-1:0] last, input int numHoles);
    if (int'(last) + 1 >= numHoles) return '0;
    return last + HOLE_W'(1);
  endfunction

endpackage

// File: rtl/mole_spawner_if.sv
// Game-side signal bundle between the spawner and its environment.
interface mole_spawner_if #(parameter int NUM_HOLES = 9);
  import mole_pkg::*;

  logic [HOLE_W-1:0]    rnd;
  logic                 tick;
  logic                 enable;
  logic [NUM_HOLES-1:0] btn;
  logic [NUM_HOLES-1:0] mole;
  logic                 hit;
  logic                 miss;
  logic [SCORE_W-1:0]   score;
  logic                 active;

  modport master (output rnd, tick, enable, btn, input mole, hit, miss, score, active);
  modport slave  (input rnd, tick, enable, btn, output mole, hit, miss, score, active);

endinterface

// File: rtl/mole_spawner_tick_timer.sv
// Tick-driven down-counter; expire fires on the tick that consumes the last count.
module tick_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_tick,
  output logic             o_expire
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_expire = i_tick && (r_count == WIDTH'(1));

endmodule

// File: rtl/mole_spawner.sv
// Mole spawner: picks a random hole, raises the mole, scores whacks and timeouts.
module mole_spawner
  import mole_pkg::*;
#(
  parameter int NUM_HOLES = 9,
  parameter int UP_TICKS  = 500,
  parameter int GAP_TICKS = 200,
  parameter int RETRY_MAX = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mole_spawner_if.slave  bus
);

  localparam int TIMER_W = $clog2(((UP_TICKS > GAP_TICKS) ? UP_TICKS : GAP_TICKS) + 1);
  localparam int RETRY_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  state_t               r_state;
  logic [HOLE_W-1:0]    r_lastHole;
  logic [RETRY_W-1:0]   r_retry;
  logic [NUM_HOLES-1:0] r_btnQ;
  logic [NUM_HOLES-1:0] r_mole;
  logic                 r_hit;
  logic                 r_miss;
  logic [SCORE_W-1:0]   r_score;

  logic                 w_fallback;
  logic                 w_pickValid;
  logic [HOLE_W-1:0]    w_pickHole;
  logic                 w_holeRise;
  logic                 w_expire;
  logic                 w_timerLoad;
  logic [TIMER_W-1:0]   w_timerValue;

  assign w_fallback  = (r_retry == RETRY_W'(RETRY_MAX));
  assign w_pickValid = w_fallback || ((int'(bus.rnd) < NUM_HOLES) && (bus.rnd != r_lastHole));
  assign w_pickHole  = w_fallback ? nextHole(r_lastHole, NUM_HOLES) : bus.rnd;
  // r_mole is one-hot on the raised hole, so it doubles as the edge mask.
  assign w_holeRise  = |(bus.btn & ~r_btnQ & r_mole);

  always_comb begin
    w_timerLoad  = 1'b0;
    w_timerValue = '0;
    if (bus.enable) begin
      case (r_state)
        ST_PICK: if (w_pickValid) begin
          w_timerLoad  = 1'b1;
          w_timerValue = TIMER_W'(UP_TICKS);
        end
        ST_UP: if (w_holeRise || w_expire) begin
          w_timerLoad  = 1'b1;
          w_timerValue = TIMER_W'(GAP_TICKS);
        end
        default: ;
      endcase
    end
  end

  tick_timer #(.WIDTH(TIMER_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_timerLoad),
    .i_value  (w_timerValue),
    .i_tick   (bus.tick),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_lastHole <= '0;
      r_retry    <= '0;
      r_btnQ     <= '0;
      r_mole     <= '0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      r_score    <= '0;
    end else begin
      r_btnQ <= bus.btn;
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      if (!bus.enable) begin
        r_state <= ST_IDLE;
        r_mole  <= '0;
        r_retry <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_score <= '0;
            r_retry <= '0;
            r_state <= ST_PICK;
          end
          ST_PICK: begin
            if (w_pickValid) begin
              r_lastHole <= w_pickHole;
              r_mole     <= NUM_HOLES'(1) << w_pickHole;
              r_retry    <= '0;
              r_state    <= ST_UP;
            end else begin
              r_retry <= r_retry + RETRY_W'(1);
            end
          end
          // A whack beats a timeout landing on the same clock.
          ST_UP: begin
            if (w_holeRise) begin
              r_hit   <= 1'b1;
              r_mole  <= '0;
              r_state <= ST_GAP;
              if (r_score != '1) r_score <= r_score + SCORE_W'(1);
            end else if (w_expire) begin
              r_miss  <= 1'b1;
              r_mole  <= '0;
              r_state <= ST_GAP;
            end
          end
          ST_GAP: begin
            if (w_expire) r_state <= ST_PICK;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.mole   = r_mole;
  assign bus.hit    = r_hit;
  assign bus.miss   = r_miss;
  assign bus.score  = r_score;
  assign bus.active = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mole_spawner.sv
// Bench for mole_spawner: directed scenarios plus random play against a round-level model.
module tb_mole_spawner;
  import mole_pkg::*;

  localparam int N    = 9;
  localparam int UPT  = 3;
  localparam int GAPT = 2;
  localparam int RMAX = 8;

  localparam int P_IDLE = 0;
  localparam int P_PICK = 1;
  localparam int P_UP   = 2;
  localparam int P_GAP  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   cmpOn = 1'b0;

  int checks = 0;
  int passes = 0;

  int mPhase = P_IDLE;
  int mHole = 0;
  int mLast = 0;
  int mRemain = 0;
  int mRejects = 0;
  int mScore = 0;
  int mChoice = 0;
  logic [N-1:0] mPrevBtn = '0;
  logic [N-1:0] mRise = '0;
  bit mHit = 1'b0;
  bit mMiss = 1'b0;

  mole_spawner_if #(.NUM_HOLES(N)) bus();

  mole_spawner #(
    .NUM_HOLES (N),
    .UP_TICKS  (UPT),
    .GAP_TICKS (GAPT),
    .RETRY_MAX (RMAX)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] onehotOf(input int h);
    return N'(1) << h;
  endfunction

  // Round-level game model: which hole is up, ticks left, rejections so far.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mPhase = P_IDLE; mHole = 0; mLast = 0; mRemain = 0; mRejects = 0;
      mScore = 0; mPrevBtn = '0; mHit = 1'b0; mMiss = 1'b0;
    end else begin
      mRise = bus.btn & ~mPrevBtn;
      mPrevBtn = bus.btn;
      mHit = 1'b0;
      mMiss = 1'b0;
      if (!bus.enable) begin
        mPhase = P_IDLE;
        mRejects = 0;
      end else begin
        case (mPhase)
          P_IDLE: begin
            mScore = 0; mRejects = 0; mPhase = P_PICK;
          end
          P_PICK: begin
            if (mRejects == RMAX) mChoice = (mLast + 1) % N;
            else if (int'(bus.rnd) < N && int'(bus.rnd) != mLast) mChoice = int'(bus.rnd);
            else mChoice = -1;
            if (mChoice < 0) mRejects++;
            else begin
              mHole = mChoice; mLast = mChoice; mRemain = UPT; mRejects = 0; mPhase = P_UP;
            end
          end
          P_UP: begin
            if (|(mRise & onehotOf(mHole))) begin
              mHit = 1'b1;
              if (mScore < 255) mScore++;
              mPhase = P_GAP; mRemain = GAPT;
            end else if (bus.tick) begin
              if (mRemain == 1) begin
                mMiss = 1'b1; mPhase = P_GAP; mRemain = GAPT;
              end else mRemain--;
            end
          end
          default: begin
            if (bus.tick) begin
              if (mRemain == 1) mPhase = P_PICK;
              else mRemain--;
            end
          end
        endcase
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #3;
    if (cmpOn) begin
      logic [N-1:0] eMole;
      logic eActive;
      eMole = (mPhase == P_UP) ? onehotOf(mHole) : '0;
      eActive = (mPhase != P_IDLE);
      checks++;
      if (bus.mole === eMole && bus.hit === mHit && bus.miss === mMiss &&
          int'(bus.score) == mScore && bus.active === eActive) passes++;
      else
        $display("[TB] FAIL cycle t=%0t mole=%b want %b hit=%b want %b miss=%b want %b score=%0d want %0d active=%b want %b",
                 $time, bus.mole, eMole, bus.hit, mHit, bus.miss, mMiss, bus.score, mScore, bus.active, eActive);
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic en, input int r, input logic tk, input logic [N-1:0] b);
    @(negedge clk);
    bus.enable = en;
    bus.rnd = HOLE_W'(r);
    bus.tick = tk;
    bus.btn = b;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic checkOutput(input string name, input logic [N-1:0] eMole, input logic eHit,
                             input logic eMiss, input int eScore, input logic eActive);
    checks++;
    if (bus.mole === eMole && bus.hit === eHit && bus.miss === eMiss &&
        int'(bus.score) == eScore && bus.active === eActive) passes++;
    else
      $display("[TB] FAIL %s mole=%b want %b hit=%b want %b miss=%b want %b score=%0d want %0d active=%b want %b",
               name, bus.mole, eMole, bus.hit, eHit, bus.miss, eMiss, bus.score, eScore, bus.active, eActive);
  endtask

  task automatic randomCycle(input int disableOdds);
    logic [N-1:0] holeBit;
    @(negedge clk);
    bus.enable = (disableOdds == 0) ? 1'b1 : ($urandom_range(0, disableOdds - 1) != 0);
    bus.rnd = HOLE_W'($urandom_range(0, 31));
    bus.tick = ($urandom_range(0, 1) == 1);
    if (mPhase == P_UP) begin
      holeBit = onehotOf(mHole);
      bus.btn = (N'($urandom) & ~holeBit) | (($urandom_range(0, 1) == 1) ? holeBit : '0);
    end else begin
      bus.btn = N'($urandom);
    end
  endtask

  initial begin
    int guard;
    logic [N-1:0] holeBit;
    bus.enable = 1'b0; bus.rnd = '0; bus.tick = 1'b0; bus.btn = '0;
    #1 rst_n = 1'b0;
    cmpOn = 1'b1;
    cycles(2);
    checkOutput("reset", '0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;

    applyStimulus(1, 3, 0, '0); cycles(2);
    checkOutput("first_pick", 9'h008, 0, 0, 0, 1);
    applyStimulus(0, 3, 0, '0); cycles(1);
    checkOutput("disable_idle", '0, 0, 0, 0, 0);

    applyStimulus(1, 0, 0, '0); cycles(1);
    checkOutput("enter_pick", '0, 0, 0, 0, 1);
    applyStimulus(1, 12, 0, '0); cycles(1);
    applyStimulus(1, 30, 0, '0); cycles(1);
    checkOutput("two_rejects", '0, 0, 0, 0, 1);
    applyStimulus(1, 5, 0, '0); cycles(1);
    checkOutput("accept_5", 9'h020, 0, 0, 0, 1);

    applyStimulus(1, 5, 1, '0); cycles(2);
    checkOutput("up_countdown", 9'h020, 0, 0, 0, 1);
    applyStimulus(1, 5, 1, 9'h020); cycles(1);
    checkOutput("hit_beats_timeout", '0, 1, 0, 1, 1);

    applyStimulus(1, 2, 1, 9'h084); cycles(3);
    checkOutput("accept_2", 9'h004, 0, 0, 1, 1);
    applyStimulus(1, 2, 0, 9'h084); cycles(1);
    checkOutput("held_btn_no_hit", 9'h004, 0, 0, 1, 1);
    applyStimulus(1, 2, 0, '0); cycles(1);
    applyStimulus(1, 2, 0, 9'h080); cycles(1);
    checkOutput("other_btn_ignored", 9'h004, 0, 0, 1, 1);
    applyStimulus(1, 6, 1, '0); cycles(2);
    checkOutput("two_ticks_no_miss", 9'h004, 0, 0, 1, 1);
    cycles(1);
    checkOutput("miss_third_tick", '0, 0, 1, 1, 1);
    cycles(1);
    checkOutput("gap_first_tick", '0, 0, 0, 1, 1);
    cycles(1);
    checkOutput("gap_to_pick", '0, 0, 0, 1, 1);
    cycles(1);
    checkOutput("gap_length_accept_6", 9'h040, 0, 0, 1, 1);

    applyStimulus(1, 8, 0, 9'h040); cycles(1);
    checkOutput("hit_6", '0, 1, 0, 2, 1);
    applyStimulus(1, 8, 1, '0); cycles(3);
    checkOutput("accept_8", 9'h100, 0, 0, 2, 1);
    applyStimulus(1, 20, 0, 9'h100); cycles(1);
    checkOutput("hit_8", '0, 1, 0, 3, 1);
    applyStimulus(1, 20, 1, '0); cycles(10);
    checkOutput("still_rejecting", '0, 0, 0, 3, 1);
    cycles(1);
    checkOutput("fallback_hole_0", 9'h001, 0, 0, 3, 1);

    applyStimulus(0, 20, 0, '0); cycles(1);
    checkOutput("disable_mid_up", '0, 0, 0, 3, 0);

    // Keep playing until the score pins at 255, then a little longer.
    guard = 0;
    while (mScore < 255 && guard < 20000) begin
      randomCycle(0);
      guard++;
    end
    if (guard >= 20000) begin
      checks++;
      $display("[TB] FAIL saturation_bound model score=%0d dut score=%0d want 255", mScore, bus.score);
    end
    repeat (200) randomCycle(0);

    guard = 0;
    do begin
      applyStimulus(1, $urandom_range(0, 8), 1, '0);
      @(posedge clk); #3;
      guard++;
    end while (mPhase != P_UP && guard < 200);
    if (guard >= 200) begin
      checks++;
      $display("[TB] FAIL reach_up_bound phase=%0d want %0d", mPhase, P_UP);
    end
    holeBit = onehotOf(mHole);
    applyStimulus(1, 0, 0, '0); cycles(1);
    applyStimulus(1, 0, 0, holeBit); cycles(1);
    checkOutput("saturated_hit", '0, 1, 0, 255, 1);

    applyStimulus(1, 0, 0, '0);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset_mid_gap", '0, 0, 0, 0, 0);
    cycles(1);
    @(negedge clk) rst_n = 1'b1;

    repeat (1500) randomCycle(40);
    cycles(1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
